field_serializer: RTL

FIELD_SERIALIZER -- requirements
Module: field_serializer

---
 rtl/fast_pkg.sv | 13 +
 rtl/field_serializer_compactor.sv | 21 ++
 rtl/field_serializer.sv | 96 +++++++++
 3 files changed

// File: rtl/fast_pkg.sv
// fast_pkg: shared field widths and field word layout for decoders and field buffering
package fast_pkg;
  localparam int BEAT_W   = 64;
  localparam int MSG_ID_W = 21;
  localparam int MAX_MSG  = 10;
  localparam int IDX_W    = $clog2(MAX_MSG);
  localparam int FIELD_W  = MSG_ID_W + IDX_W + BEAT_W;
  typedef struct packed {
    logic [MSG_ID_W-1:0] msg_id;
    logic [IDX_W-1:0]    field_idx;
    logic [BEAT_W-1:0]   data;
  } field_t;
endpackage

// File: rtl/field_serializer_compactor.sv
// lane_compactor: valid-lane popcount and exclusive prefix-sum destination offsets
module lane_compactor
  import fast_pkg::*;
#(
  parameter int N     = 4,
  parameter int CNT_W = $clog2(N + 1)
) (
  input  logic [N-1:0]            i_valid,
  output logic [CNT_W-1:0]        o_count,
  output logic [N-1:0][CNT_W-1:0] o_offset
);
  // each valid lane lands after all lower-numbered valid lanes
  always_comb begin
    o_count  = '0;
    o_offset = '0;
    for (int i = 0; i < N; i++) begin
      o_offset[i] = o_count;
      o_count     = o_count + CNT_W'(i_valid[i]);
    end
  end
endmodule

// File: rtl/field_serializer.sv
// field_serializer: compacts parallel decoder lanes into a circular buffer and serializes fields
module field_serializer
  import fast_pkg::*;
#(
  parameter int NUM_DECODERS     = 4,
  parameter int BEAT_WIDTH       = 64,
  parameter int MAX_MESSAGE_SIZE = 10,
  parameter int MESSAGE_ID_SIZE  = 21,
  parameter int DEPTH            = 8,
  localparam int IDX_W   = $clog2(MAX_MESSAGE_SIZE),
  localparam int FIELD_W = MESSAGE_ID_SIZE + IDX_W + BEAT_WIDTH,
  localparam int OCC_W   = $clog2(DEPTH) + 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_DECODERS-1:0][FIELD_W:0] in_fields,
  output logic                             in_ready,
  output logic [FIELD_W-1:0]               out_field,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             out_msg_start,
  output logic [15:0]                      drop_count,
  output logic [OCC_W-1:0]                 occupancy
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(NUM_DECODERS + 1);
  logic [FIELD_W-1:0]                    r_mem [DEPTH];
  logic [PTR_W-1:0]                      r_wr_ptr, r_rd_ptr;
  logic [OCC_W-1:0]                      r_occ;
  logic [15:0]                           r_drop;
  logic [FIELD_W-1:0]                    r_out_field;
  logic [MESSAGE_ID_SIZE-1:0]            r_last_id;
  logic                                  r_last_vld;
  logic [NUM_DECODERS-1:0]               w_valid;
  logic [CNT_W-1:0]                      w_count, w_push_cnt;
  logic [NUM_DECODERS-1:0][CNT_W-1:0]    w_offset;
  logic                                  w_pop;
  logic [PTR_W-1:0]                      w_next_rd;
  logic [OCC_W-1:0]                      w_remain;
  logic [FIELD_W-1:0]                    w_first, w_head;
  logic [16:0]                           w_drop_sum;
  // split valid flags and find the lowest valid lane, which lands at wr_ptr
  always_comb begin
    w_valid = '0;
    w_first = '0;
    for (int i = NUM_DECODERS - 1; i >= 0; i--) begin
      w_valid[i] = in_fields[i][FIELD_W];
      if (w_valid[i]) w_first = in_fields[i][FIELD_W-1:0];
    end
  end
  lane_compactor #(.N(NUM_DECODERS), .CNT_W(CNT_W)) u_compact (
    .i_valid (w_valid),
    .o_count (w_count),
    .o_offset(w_offset)
  );
  assign in_ready      = (OCC_W'(DEPTH) - r_occ) >= OCC_W'(NUM_DECODERS);
  assign out_valid     = r_occ != '0;
  assign w_pop         = out_valid & out_ready;
  assign w_push_cnt    = in_ready ? w_count : '0;
  assign w_next_rd     = r_rd_ptr + PTR_W'(w_pop);
  assign w_remain      = r_occ - OCC_W'(w_pop);
  assign w_head        = (w_remain == '0) ? w_first : r_mem[w_next_rd];
  assign w_drop_sum    = {1'b0, r_drop} + 17'(w_count);
  assign out_field     = r_out_field;
  assign out_msg_start = out_valid & (~r_last_vld | (r_out_field[FIELD_W-1 -: MESSAGE_ID_SIZE] != r_last_id));
  assign drop_count    = r_drop;
  assign occupancy     = r_occ;
  // accepted lanes go to consecutive entries from wr_ptr, wrapping past the top entry
  always_ff @(posedge clk) begin
    if (!rst && in_ready)
      for (int i = 0; i < NUM_DECODERS; i++)
        if (w_valid[i]) r_mem[r_wr_ptr + PTR_W'(w_offset[i])] <= in_fields[i][FIELD_W-1:0];
  end
  // pointers, occupancy, drop counter, registered head read and last popped message id
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_occ       <= '0;
      r_drop      <= '0;
      r_out_field <= '0;
      r_last_id   <= '0;
      r_last_vld  <= 1'b0;
    end else begin
      r_wr_ptr    <= r_wr_ptr + PTR_W'(w_push_cnt);
      r_rd_ptr    <= w_next_rd;
      r_occ       <= r_occ + OCC_W'(w_push_cnt) - OCC_W'(w_pop);
      r_out_field <= w_head;
      if (!in_ready && w_count != '0) r_drop <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
      if (w_pop) begin
        r_last_id  <= r_out_field[FIELD_W-1 -: MESSAGE_ID_SIZE];
        r_last_vld <= 1'b1;
      end
    end
  end
endmodule
